// File: rtl/spi_slave_ram_link_if.sv
// Bundle between the SPI slave front end and its environment: SPI pins plus
// the rx/tx handshake toward the RAM.
interface spi_slave_ram_link_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_ram_link.sv
// SPI slave: deserialises MOSI into DATA_W+2-bit command words for the RAM and
// serialises the RAM's read byte back on MISO for read-data commands.
module spi_slave_ram_link #(
    parameter int DATA_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_slave_ram_link_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam int TXC_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   sr;
    logic              word_done;
    logic              rd_addr_done;
    logic              tx_busy;
    logic              tx_done;
    logic [TXC_W-1:0]  tx_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic              miso;
    logic [DATA_W+1:0] rx_word;
    logic              rx_strobe;
    logic              abort;

    assign abort        = (state != IDLE) && bus.SS_n;
    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_word;
    assign bus.rx_valid = rx_strobe;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Deselect wins over every other transition, including the command bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.SS_n) state_next = CHK_CMD;
            CHK_CMD: begin
                if (!bus.MOSI)        state_next = WRITE;
                else if (rd_addr_done) state_next = READ_DATA;
                else                  state_next = READ_ADD;
            end
            default: state_next = state;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            word_done    <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_cnt       <= '0;
            miso         <= 1'b0;
            rx_word      <= '0;
            rx_strobe    <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (abort) begin
                // A partial word is dropped; rd_addr_done keeps its value.
                cnt       <= '0;
                sr        <= '0;
                tx_sr     <= '0;
                word_done <= 1'b0;
                tx_busy   <= 1'b0;
                tx_done   <= 1'b0;
                tx_cnt    <= '0;
                miso      <= 1'b0;
            end else begin
                case (state)
                    CHK_CMD: begin
                        sr  <= {{DATA_W{1'b0}}, bus.MOSI};
                        cnt <= CNT_W'(1);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!word_done) begin
                            sr  <= {sr[DATA_W-1:0], bus.MOSI};
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_W'(DATA_W + 1)) begin
                                rx_word   <= {sr, bus.MOSI};
                                rx_strobe <= 1'b1;
                                word_done <= 1'b1;
                                if (state == READ_ADD)  rd_addr_done <= 1'b1;
                                if (state == READ_DATA) rd_addr_done <= 1'b0;
                            end
                        end else if (state == READ_DATA) begin
                            // One byte per frame: wait, shift out MSB first, then idle low.
                            if (!tx_busy && !tx_done) begin
                                if (bus.tx_valid) begin
                                    miso    <= bus.tx_data[DATA_W-1];
                                    tx_sr   <= bus.tx_data << 1;
                                    tx_cnt  <= TXC_W'(1);
                                    tx_busy <= 1'b1;
                                end
                            end else if (tx_busy) begin
                                if (tx_cnt == TXC_W'(DATA_W)) begin
                                    miso    <= 1'b0;
                                    tx_busy <= 1'b0;
                                    tx_done <= 1'b1;
                                end else begin
                                    miso   <= tx_sr[DATA_W-1];
                                    tx_sr  <= tx_sr << 1;
                                    tx_cnt <= tx_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
